// File: rtl/mult_seq_pkg.sv
// Shared types and width helpers for the multiplier front-end sequencer.
package mult_seq_pkg;

  localparam int OPERAND_W = 4;
  localparam int PROD_W    = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    RELEASE = 3'd3,
    OUTPUT  = 3'd4
  } seq_state_t;

  // Bits needed to hold a count in the range 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to address n entries.
  function automatic int ptr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head output; push/pop are
// ignored when full/empty so the pointers can never run past each other.
module sync_fifo
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW    = ptr_w(DEPTH);
  localparam int CNT_W = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/mult_dot_sequencer.sv
// Buffers operand pairs, drives the 4-bit multiplier one product at a time and
// sums N_TERMS products onto a valid/ready output. Optional: MULT_TIMEOUT_EN.
module mult_dot_sequencer
  import mult_seq_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int N_TERMS     = 4,
  parameter int ACC_W       = 10,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPERAND_W-1:0] in_a,
  input  logic [OPERAND_W-1:0] in_b,
  output logic                 mul_ena,
  output logic [OPERAND_W-1:0] mul_a,
  output logic [OPERAND_W-1:0] mul_b,
  input  logic [PROD_W-1:0]    mul_y,
  input  logic                 mul_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_sum,
  output logic                 busy,
  output logic                 err,
  output logic [2:0]           state
);

  localparam int TC_W = cnt_w(N_TERMS);

  seq_state_t                 state_q;
  logic [ACC_W-1:0]           acc;
  logic [TC_W-1:0]            term_cnt;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       push;
  logic                       pop;
  logic [2*OPERAND_W-1:0]     head;

  // Handshake: a pair is taken on any cycle where in_valid && in_ready, and a
  // sum is handed over on any cycle where out_valid && out_ready.
  assign in_ready = !fifo_full && !rst;
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == ISSUE);
  assign busy     = (state_q != IDLE);
  assign state    = state_q;

  sync_fifo #(
    .WIDTH (2*OPERAND_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({in_a, in_b}),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef MULT_TIMEOUT_EN
  localparam int WC_W = cnt_w(TIMEOUT_CYC);
  logic [WC_W-1:0] wait_cnt;
  logic            err_q;
  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mul_ena   <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      acc       <= '0;
      term_cnt  <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
`ifdef MULT_TIMEOUT_EN
      wait_cnt  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      mul_ena <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) state_q <= ISSUE;
        end
        ISSUE: begin
          mul_ena <= 1'b1;
          mul_a   <= head[2*OPERAND_W-1:OPERAND_W];
          mul_b   <= head[OPERAND_W-1:0];
          state_q <= WAIT;
`ifdef MULT_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (mul_done) begin
            acc      <= acc + ACC_W'(mul_y);
            term_cnt <= term_cnt + 1'b1;
            state_q  <= RELEASE;
          end
`ifdef MULT_TIMEOUT_EN
          else if (wait_cnt == WC_W'(TIMEOUT_CYC - 1)) begin
            // A lost product still consumes its slot, as a zero term.
            err_q    <= 1'b1;
            term_cnt <= term_cnt + 1'b1;
            state_q  <= RELEASE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RELEASE: begin
          // done is a level: hold here until it drops so it is counted once.
          if (!mul_done) begin
            if (term_cnt == TC_W'(N_TERMS)) begin
              out_valid <= 1'b1;
              out_sum   <= acc;
              state_q   <= OUTPUT;
            end else if (!fifo_empty) begin
              state_q <= ISSUE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            acc       <= '0;
            term_cnt  <= '0;
            out_valid <= 1'b0;
            state_q   <= fifo_empty ? IDLE : ISSUE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_dot_sequencer.sv
// Self-checking bench for mult_dot_sequencer: behavioural multiplier plus a
// dot-product reference model; honours MULT_TIMEOUT_EN when defined.
module tb_mult_dot_sequencer;

  localparam int DEPTH   = 4;
  localparam int N_TERMS = 4;
  localparam int ACC_W   = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_a;
  logic [3:0]       in_b;
  logic             mul_ena;
  logic [3:0]       mul_a;
  logic [3:0]       mul_b;
  logic [7:0]       mul_y;
  logic             mul_done;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             busy;
  logic             err;
  logic [2:0]       state;

  always #5 clk = ~clk;

  mult_dot_sequencer #(
    .DEPTH       (DEPTH),
    .N_TERMS     (N_TERMS),
    .ACC_W       (ACC_W),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_ena   (mul_ena),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_y     (mul_y),
    .mul_done  (mul_done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy),
    .err       (err),
    .state     (state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: every N_TERMS accepted pairs produce one expected sum.
  logic [ACC_W-1:0] exp_q[$];
  int part_n   = 0;
  int part_sum = 0;

  function automatic void model_term(input int p);
    part_sum += p;
    part_n++;
    if (part_n == N_TERMS) begin
      exp_q.push_back(ACC_W'(part_sum));
      part_n   = 0;
      part_sum = 0;
    end
  endfunction

  // Behavioural multiplier: latency and done-hold are set by the test.
  int   mult_lat  = 6;
  int   mult_hold = 1;
  bit   mult_dead = 1'b0;
  logic [3:0] ma, mb;

  initial begin
    mul_done = 1'b0;
    mul_y    = 8'd0;
    forever begin
      @(posedge clk); #1;
      if (mul_ena && !mult_dead) begin
        ma = mul_a;
        mb = mul_b;
        repeat (mult_lat) @(posedge clk);
        #1;
        mul_y    = {4'b0, ma} * {4'b0, mb};
        mul_done = 1'b1;
        repeat (mult_hold) @(posedge clk);
        #1;
        mul_done = 1'b0;
      end
    end
  end

  bit rnd_ready = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor: scoreboard pops, hold-stability and ena pulse width.
  int   ena_cnt = 0;
  int   out_cnt = 0;
  logic prev_hold = 1'b0;
  logic prev_ena  = 1'b0;
  logic [ACC_W-1:0] prev_sum = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (mul_ena) begin
        ena_cnt++;
        check("ena_width", prev_ena, 1'b0);
      end
      if (prev_hold) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_sum", out_sum, prev_sum);
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) check("spurious_out", out_valid, 1'b0);
        else check("sum", out_sum, exp_q.pop_front());
      end
    end
    prev_hold = out_valid && !out_ready && !rst;
    prev_sum  = out_sum;
    prev_ena  = mul_ena && !rst;
  end

  task automatic push_pair(input logic [3:0] a, input logic [3:0] b);
    bit took = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int g = 0; g < 200 && !took; g++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (took) model_term(mult_dead ? 0 : int'(a) * int'(b));
    else check("push_timeout", took, 1'b1);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (state === s) break;
    end
    check(tag, state, s);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) break;
    end
    check(tag, out_valid, 1'b1);
  endtask

  task automatic drain(input int budget, input string tag);
    for (int n = 0; n < budget; n++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check(tag, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 4'd0;
    in_b      = 4'd0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", state, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_ena", mul_ena, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_sum", out_sum, 0);
    check("rst_err", err, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Single dot product with first-issue latency
    mult_lat = 6; mult_hold = 1;
    ena_cnt = 0; out_cnt = 0;
    push_pair(4'd3, 4'd5);
    @(negedge clk); check("lat_idle", mul_ena, 1'b0);
    @(negedge clk); check("lat_issue", state, 3'd1);
    @(negedge clk); check("lat_ena", mul_ena, 1'b1);
    @(posedge clk); #1;
    push_pair(4'd15, 4'd15);
    push_pair(4'd0, 4'd9);
    push_pair(4'd7, 4'd2);
    wait_valid(200, "t1_valid");
    check("t1_sum", out_sum, 254);
    drain(50, "t1_drain");
    check("t1_ena_cnt", ena_cnt, 4);
    check("t1_out_cnt", out_cnt, 1);

    // Backpressure: sum held while the FIFO fills behind it
    out_ready = 1'b0;
    push_pair(4'd3, 4'd5);
    push_pair(4'd15, 4'd15);
    push_pair(4'd0, 4'd9);
    push_pair(4'd7, 4'd2);
    wait_valid(200, "bp_valid");
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++)
      push_pair(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    @(negedge clk);
    check("bp_full", in_ready, 1'b0);
    check("bp_state", state, 3'd4);
    repeat (20) @(negedge clk);
    check("bp_hold_sum", out_sum, 254);
    check("bp_hold_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain(300, "bp_drain");

    // Done held high for several cycles
    mult_lat = 2; mult_hold = 5;
    push_pair(4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)));
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (mul_done) break;
    end
    repeat (4) @(negedge clk);
    check("dh_release", state, 3'd3);
    check("dh_busy", busy, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < N_TERMS - 1; i++)
      push_pair(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    drain(300, "dh_drain");

    // Starved input: partial sum retained across IDLE
    mult_lat = 3; mult_hold = 1;
    push_pair(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    push_pair(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    repeat (30) @(negedge clk);
    check("st_state", state, 3'd0);
    check("st_busy", busy, 1'b0);
    check("st_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    push_pair(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    push_pair(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    drain(300, "st_drain");

    // Reset during WAIT; the late done must not leak into the next sum
    mult_lat = 10; mult_hold = 1;
    push_pair(4'd9, 4'd11);
    wait_state(3'd2, 20, "rw_wait");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rw_state", state, 3'd0);
    check("rw_busy", busy, 1'b0);
    check("rw_ena", mul_ena, 1'b0);
    check("rw_mul_a", mul_a, 0);
    check("rw_mul_b", mul_b, 0);
    check("rw_valid", out_valid, 1'b0);
    check("rw_sum", out_sum, 0);
    check("rw_err", err, 1'b0);
    check("rw_in_ready", in_ready, 1'b0);
    part_n = 0; part_sum = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("rw_idle", state, 3'd0);
    @(posedge clk); #1;
    mult_lat = 2;
    for (int i = 0; i < N_TERMS; i++)
      push_pair(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    drain(300, "rw_drain");

    // Randomized traffic with random latency and backpressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 8 * N_TERMS; i++) begin
      mult_lat  = $urandom_range(1, 6);
      mult_hold = $urandom_range(1, 4);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      push_pair(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    drain(2000, "rnd_drain");
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

`ifdef MULT_TIMEOUT_EN
    // Multiplier never answers: each term times out as a zero product
    mult_dead = 1'b1;
    push_pair(4'd5, 4'd6);
    wait_state(3'd2, 20, "to_wait");
    repeat (15) @(negedge clk);
    check("to_err_early", err, 1'b0);
    @(negedge clk);
    check("to_err_set", err, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < N_TERMS - 1; i++) push_pair(4'd7, 4'd7);
    drain(400, "to_drain");
    check("to_err_sticky", err, 1'b1);
    mult_dead = 1'b0;
`else
    check("err_tied", err, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
